// File: rtl/countdown_sequencer.sv
// countdown_sequencer
//   Round-start controller and final pixel compositor. After start it shows
//   the 3, 2, 1 and FIGHT sprites for a number of frames each, with frames
//   counted from the falling edge of VGA vsync. It then raises fight_enable
//   until round_over. Each cycle the active sprite pixel is keyed over the
//   scene pixel, and the result is registered onto the VGA colour pins.
//   Optional feature macro: COUNTDOWN_SKIP_EN adds a skip input that jumps
//   straight to DONE from any countdown stage.
module countdown_sequencer #(
  parameter int          FRAMES_PER_STEP = 60,
  parameter int          FIGHT_FRAMES    = 45,
  parameter int          CNT_W           = 8,
  parameter logic [11:0] KEY_RGB         = 12'h000
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  input  logic        vs,
  input  logic        blank,
  input  logic        start,
  input  logic        round_over,
`ifdef COUNTDOWN_SKIP_EN
  input  logic        skip,
`endif
  input  logic [11:0] cd3_rgb,
  input  logic [11:0] cd2_rgb,
  input  logic [11:0] cd1_rgb,
  input  logic [11:0] fight_rgb,
  input  logic [11:0] game_rgb,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic [2:0]  stage,
  output logic        fight_enable,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CD3   = 3'd1,
    ST_CD2   = 3'd2,
    ST_CD1   = 3'd3,
    ST_FIGHT = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [CNT_W-1:0] FIGHT_LAST = CNT_W'(FIGHT_FRAMES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             vs_q_reg;
  logic             tick;
  logic             skip_req;
  logic             counting;
  logic [11:0]      sel_rgb;
  logic [11:0]      pix_next;
  logic [11:0]      rgb_reg;
  logic [2:0]       stage_reg;
  logic             fight_enable_reg;
  logic             busy_reg;

`ifdef COUNTDOWN_SKIP_EN
  assign skip_req = skip;
`else
  assign skip_req = 1'b0;
`endif

  // One pulse per frame on the vsync falling edge
  assign tick = vs_q_reg & ~vs;

  // Delay vsync by one cycle for edge detection
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) vs_q_reg <= 1'b1;
    else          vs_q_reg <= vs;
  end

  // Next-state and frame-counter logic; round_over beats skip, skip beats start/ticks
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    counting   = (state_reg == ST_CD3) || (state_reg == ST_CD2) ||
                 (state_reg == ST_CD1) || (state_reg == ST_FIGHT);
    if (state_reg != ST_IDLE && round_over) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else if (counting && skip_req) begin
      state_next = ST_DONE;
      cnt_next   = '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (start && !round_over) begin
            state_next = ST_CD3;
            cnt_next   = '0;
          end
        end
        ST_CD3, ST_CD2, ST_CD1: begin
          if (tick) begin
            if (cnt_reg == STEP_LAST) begin
              state_next = state_t'(state_reg + 3'd1);
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
        end
        ST_FIGHT: begin
          if (tick) begin
            if (cnt_reg == FIGHT_LAST) begin
              state_next = ST_DONE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State, counter and status registers
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= ST_IDLE;
      cnt_reg          <= '0;
      stage_reg        <= 3'd0;
      fight_enable_reg <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      stage_reg        <= state_next;
      fight_enable_reg <= (state_next == ST_DONE);
      busy_reg         <= (state_next == ST_CD3) || (state_next == ST_CD2) ||
                          (state_next == ST_CD1) || (state_next == ST_FIGHT);
    end
  end

  // Sprite overlay driven by the current (pre-transition) state
  always_comb begin
    sel_rgb = KEY_RGB;
    unique case (state_reg)
      ST_CD3:   sel_rgb = cd3_rgb;
      ST_CD2:   sel_rgb = cd2_rgb;
      ST_CD1:   sel_rgb = cd1_rgb;
      ST_FIGHT: sel_rgb = fight_rgb;
      default:  sel_rgb = KEY_RGB;
    endcase
    if (!blank)                   pix_next = 12'h000;
    else if (sel_rgb != KEY_RGB)  pix_next = sel_rgb;
    else                          pix_next = game_rgb;
  end

  // Registered colour output
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) rgb_reg <= 12'h000;
    else          rgb_reg <= pix_next;
  end

  assign red          = rgb_reg[11:8];
  assign green        = rgb_reg[7:4];
  assign blue         = rgb_reg[3:0];
  assign stage        = stage_reg;
  assign fight_enable = fight_enable_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Testbench for countdown_sequencer: small frame counts, vsync every 20 cycles,
// random pixels and control pulses checked against a frame-level reference model.
module tb_countdown_sequencer;

  localparam int FPS       = 2;
  localparam int FF        = 3;
  localparam int VS_PERIOD = 20;

  logic        vga_clk = 1'b0;
  logic        reset_n, vs, blank, start, round_over;
  logic [11:0] cd3_rgb, cd2_rgb, cd1_rgb, fight_rgb, game_rgb;
  logic [3:0]  red, green, blue;
  logic [2:0]  stage;
  logic        fight_enable, busy;
  logic        skip_now;
`ifdef COUNTDOWN_SKIP_EN
  logic        skip;
  assign skip = skip_now;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: stage number and frames already shown in it
  int          m_stage, m_frames;
  logic        m_vs_prev;
  logic [11:0] m_rgb;
  int          fall_count;
  int          vs_cnt;
  bit          auto_vs, rand_pix;

  countdown_sequencer #(
    .FRAMES_PER_STEP(FPS),
    .FIGHT_FRAMES(FF),
    .CNT_W(8),
    .KEY_RGB(12'h000)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .vs(vs), .blank(blank),
    .start(start), .round_over(round_over),
`ifdef COUNTDOWN_SKIP_EN
    .skip(skip),
`endif
    .cd3_rgb(cd3_rgb), .cd2_rgb(cd2_rgb), .cd1_rgb(cd1_rgb),
    .fight_rgb(fight_rgb), .game_rgb(game_rgb),
    .red(red), .green(green), .blue(blue),
    .stage(stage), .fight_enable(fight_enable), .busy(busy)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic int frames_for(int s);
    return (s == 4) ? FF : FPS;
  endfunction

  function automatic logic [16:0] exp_vec();
    return {3'(m_stage), 1'(m_stage == 5), 1'(m_stage >= 1 && m_stage <= 4), m_rgb};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {stage, fight_enable, busy, red, green, blue};
  endfunction

  task automatic model_reset();
    m_stage = 0; m_frames = 0; m_vs_prev = 1'b1; m_rgb = 12'h000;
  endtask

  // Advance one clock: drive vs/pixels, predict, clock, commit prediction
  task automatic cycle();
    logic        t;
    logic [11:0] sel, nrgb;
    int          ns, nf;
    if (auto_vs) begin
      vs = (vs_cnt != VS_PERIOD - 1);
      vs_cnt = (vs_cnt + 1) % VS_PERIOD;
    end
    if (rand_pix) begin
      cd3_rgb   = ($urandom_range(0, 1) != 0) ? 12'($urandom) : 12'h000;
      cd2_rgb   = ($urandom_range(0, 1) != 0) ? 12'($urandom) : 12'h000;
      cd1_rgb   = ($urandom_range(0, 1) != 0) ? 12'($urandom) : 12'h000;
      fight_rgb = ($urandom_range(0, 1) != 0) ? 12'($urandom) : 12'h000;
      game_rgb  = 12'($urandom);
      blank     = ($urandom_range(0, 3) != 0);
    end
    t = m_vs_prev && !vs;
    if (t) fall_count++;
    case (m_stage)
      1: sel = cd3_rgb;
      2: sel = cd2_rgb;
      3: sel = cd1_rgb;
      4: sel = fight_rgb;
      default: sel = 12'h000;
    endcase
    if (!blank) nrgb = 12'h000;
    else if (m_stage >= 1 && m_stage <= 4 && sel != 12'h000) nrgb = sel;
    else nrgb = game_rgb;
    ns = m_stage; nf = m_frames;
    if (m_stage != 0 && round_over) begin
      ns = 0; nf = 0;
    end else if (m_stage >= 1 && m_stage <= 4 && skip_now) begin
      ns = 5; nf = 0;
    end else if (m_stage == 0) begin
      if (start && !round_over) begin ns = 1; nf = 0; end
    end else if (m_stage <= 4 && t) begin
      if (m_frames + 1 == frames_for(m_stage)) begin ns = m_stage + 1; nf = 0; end
      else nf = m_frames + 1;
    end
    @(posedge vga_clk);
    @(negedge vga_clk);
    m_stage = ns; m_frames = nf; m_vs_prev = vs; m_rgb = nrgb;
    start = 1'b0; round_over = 1'b0; skip_now = 1'b0;
  endtask

  task automatic run_to_stage(int target, int budget);
    int n;
    n = 0;
    while (m_stage != target && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (m_stage != target) begin
      errors++;
      $display("FAIL run_to_stage: model stage %0d required %0d within %0d cycles", m_stage, target, budget);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; vs = 1'b1; blank = 1'b1; start = 1'b0; round_over = 1'b0; skip_now = 1'b0;
    cd3_rgb = 12'h111; cd2_rgb = 12'h222; cd1_rgb = 12'h333; fight_rgb = 12'h444; game_rgb = 12'h555;
    model_reset();
    repeat (3) @(negedge vga_clk);
    checks++;
    if (dut_vec() !== 17'h0) begin
      errors++;
      $display("FAIL reset_state: got %h required %h", dut_vec(), 17'h0);
    end
    reset_n = 1'b1; vs_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL idle_after_reset: got %h required %h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_sequence();
    int prev, mark;
    start = 1'b1;
    prev = 0; mark = fall_count;
    for (int i = 0; i < 400 && m_stage != 5; i++) begin
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL sequence_cycle: got %h required %h", dut_vec(), exp_vec());
      end
      if (stage != 3'(prev)) begin
        if (prev >= 1) begin
          checks++;
          if (fall_count - mark != frames_for(prev)) begin
            errors++;
            $display("FAIL stage_length: stage %0d lasted %0d ticks required %0d", prev, fall_count - mark, frames_for(prev));
          end
        end
        mark = fall_count;
        prev = int'(stage);
      end
    end
    checks++;
    if (stage !== 3'd5 || fight_enable !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL sequence_done: stage %0d fe %b busy %b required 5 1 0", stage, fight_enable, busy);
    end
    repeat (25) cycle();
    round_over = 1'b1;
    cycle();
    checks++;
    if (dut_vec() !== exp_vec() || stage !== 3'd0) begin
      errors++;
      $display("FAIL round_over_done: got %h required %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_pixel();
    rand_pix = 1'b0; blank = 1'b1;
    start = 1'b1;
    run_to_stage(2, 200);
    cd2_rgb = 12'hF00; game_rgb = 12'h0A5;
    cycle();
    checks++;
    if ({red, green, blue} !== 12'hF00 || m_rgb !== 12'hF00) begin
      errors++;
      $display("FAIL pixel_sprite: got %h required %h", {red, green, blue}, 12'hF00);
    end
    cd2_rgb = 12'h000;
    cycle();
    checks++;
    if ({red, green, blue} !== 12'h0A5 || m_rgb !== 12'h0A5) begin
      errors++;
      $display("FAIL pixel_key: got %h required %h", {red, green, blue}, 12'h0A5);
    end
    cd2_rgb = 12'hF00; blank = 1'b0;
    cycle();
    checks++;
    if ({red, green, blue} !== 12'h000) begin
      errors++;
      $display("FAIL pixel_blank: got %h required %h", {red, green, blue}, 12'h000);
    end
    blank = 1'b1;
    round_over = 1'b1;
    cycle();
  endtask

  task automatic test_abort();
    int mark;
    start = 1'b1;
    run_to_stage(3, 200);
    start = 1'b1; round_over = 1'b1;
    cycle();
    checks++;
    if (stage !== 3'd0 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL abort_cd1: got %h required %h", dut_vec(), exp_vec());
    end
    start = 1'b1;
    cycle();
    mark = fall_count;
    while (m_stage == 1) begin
      start = 1'b1;
      cycle();
    end
    checks++;
    if (stage !== 3'd2 || fall_count - mark != FPS) begin
      errors++;
      $display("FAIL start_in_cd3: stage %0d after %0d ticks required 2 after %0d", stage, fall_count - mark, FPS);
    end
    round_over = 1'b1;
    cycle();
  endtask

  task automatic test_vs_hold();
    auto_vs = 1'b0; vs = 1'b1;
    cycle();
    start = 1'b1;
    cycle();
    vs = 1'b0;
    repeat (10) cycle();
    vs = 1'b1;
    repeat (5) cycle();
    checks++;
    if (stage !== 3'd1 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL vs_hold_one_tick: stage %0d required 1", stage);
    end
    vs = 1'b0;
    repeat (10) cycle();
    vs = 1'b1;
    cycle();
    checks++;
    if (stage !== 3'd2 || dut_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL vs_hold_second_tick: stage %0d required 2", stage);
    end
    round_over = 1'b1;
    cycle();
    auto_vs = 1'b1; vs_cnt = 0;
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    run_to_stage(2, 200);
    repeat (3) cycle();
    blank = 1'b1; game_rgb = 12'hABC;
    reset_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 17'h0) begin
      errors++;
      $display("FAIL reset_mid_cd2: got %h required %h", dut_vec(), 17'h0);
    end
    model_reset();
    vs = 1'b0;
    @(negedge vga_clk);
    vs = 1'b1;
    @(negedge vga_clk);
    reset_n = 1'b1; vs_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      checks++;
      if (dut_vec() !== exp_vec() || stage !== 3'd0) begin
        errors++;
        $display("FAIL after_reset_idle: got %h required %h", dut_vec(), exp_vec());
      end
    end
  endtask

`ifdef COUNTDOWN_SKIP_EN
  task automatic test_skip();
    skip_now = 1'b1;
    cycle();
    checks++;
    if (stage !== 3'd0 || fight_enable !== 1'b0) begin
      errors++;
      $display("FAIL skip_idle: stage %0d required 0", stage);
    end
    start = 1'b1;
    cycle();
    skip_now = 1'b1;
    cycle();
    checks++;
    if (stage !== 3'd5 || fight_enable !== 1'b1) begin
      errors++;
      $display("FAIL skip_cd3: stage %0d fe %b required 5 1", stage, fight_enable);
    end
    round_over = 1'b1;
    cycle();
  endtask
`endif

  task automatic test_random();
    rand_pix = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      start      = ($urandom_range(0, 9) == 0);
      round_over = ($urandom_range(0, 149) == 0);
`ifdef COUNTDOWN_SKIP_EN
      skip_now   = ($urandom_range(0, 199) == 0);
`endif
      cycle();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %h required %h", i, dut_vec(), exp_vec());
      end
    end
    rand_pix = 1'b0;
  endtask

  initial begin
    auto_vs = 1'b1; rand_pix = 1'b0; fall_count = 0; vs_cnt = 0;
    test_reset();
    test_sequence();
    test_pixel();
    test_abort();
    test_vs_hold();
    test_reset_mid();
`ifdef COUNTDOWN_SKIP_EN
    test_skip();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
